// File: rtl/count_seq_ctrl.sv
// Run/pause/clear controlled 0..99 up/down counter with BCD outputs and a prescaled step tick.
// Optional feature: define COUNT_SEQ_LIMIT_STOP_EN to stop in DONE at the boundary instead of wrapping.
module count_seq_ctrl #(
    parameter int unsigned TICK_DIV = 10,
    parameter bit          INIT_UP  = 1'b1
) (
    input  logic       in_clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       dir_toggle,
    input  logic       load,
    input  logic [6:0] load_val,
    output logic [6:0] q,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       up,
    output logic       running,
    output logic       tick
);

    localparam int unsigned PreW   = 24;
    localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);
    localparam logic [6:0]  QMax   = 7'd99;

`ifdef COUNT_SEQ_LIMIT_STOP_EN
    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;
`else
    typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;
`endif

    state_e          state_q, state_d;
    logic [6:0]      q_q, q_d;
    logic [PreW-1:0] pre_q, pre_d;
    logic            up_q, up_d;

    logic [6:0] step_val;
    logic [6:0] load_sat;
    logic       at_limit;

    // Next count value in the current direction, wrapping at the 0/99 boundary.
    always_comb begin
        step_val = q_q;
        if (up_q) begin
            step_val = (q_q == QMax) ? 7'd0 : q_q + 7'd1;
        end else begin
            step_val = (q_q == 7'd0) ? QMax : q_q - 7'd1;
        end
    end

    assign load_sat = (load_val > QMax) ? QMax : load_val;
    assign at_limit = up_q ? (q_q == QMax) : (q_q == 7'd0);

    assign tick    = (state_q == StRun) && (pre_q == PreMax);
    assign running = (state_q == StRun);
    assign q       = q_q;
    assign up      = up_q;
    assign tens    = 4'(q_q / 7'd10);
    assign ones    = 4'(q_q % 7'd10);

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        pre_d   = '0;
        up_d    = up_q ^ dir_toggle;

        case (state_q)
            StIdle: begin
                // stop is a no-op here but still outranks load.
                if (start) begin
                    state_d = StRun;
                end else if (load && !stop) begin
                    q_d = load_sat;
                end
            end
            StRun: begin
                pre_d = tick ? '0 : pre_q + 1'b1;
                if (tick) begin
`ifdef COUNT_SEQ_LIMIT_STOP_EN
                    if (at_limit) begin
                        state_d = StDone;
                    end else begin
                        q_d = step_val;
                    end
`else
                    q_d = step_val;
`endif
                end
                if (stop) begin
                    state_d = StPause;
                end
            end
            StPause: begin
                if (stop) begin
                    state_d = StIdle;
                    q_d     = 7'd0;
                end else if (start) begin
                    state_d = StRun;
                end else if (load) begin
                    q_d = load_sat;
                end
            end
`ifdef COUNT_SEQ_LIMIT_STOP_EN
            StDone: begin
                // Restart is only meaningful once the direction points away from the limit.
                if (stop) begin
                    state_d = StIdle;
                    q_d     = 7'd0;
                end else if (start && !at_limit) begin
                    state_d = StRun;
                end
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge in_clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            q_q     <= 7'd0;
            pre_q   <= '0;
            up_q    <= INIT_UP;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            pre_q   <= pre_d;
            up_q    <= up_d;
        end
    end

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Self-checking bench for count_seq_ctrl: vector table, directed corner sequences, random vs model.
module tb_count_seq_ctrl;

    localparam int TD = 4;

    logic       in_clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, stop = 1'b0, dir_toggle = 1'b0, load = 1'b0;
    logic [6:0] load_val = 7'd0;
    logic [6:0] q;
    logic [3:0] tens, ones;
    logic       up, running, tick;

    int total = 0;
    int bad   = 0;

    // Reference model: 0 idle, 1 run, 2 pause, 3 done; m_cnt counts cycles spent in RUN.
    int m_st, m_q, m_cnt;
    bit m_up;

    count_seq_ctrl #(.TICK_DIV(TD), .INIT_UP(1'b1)) dut (
        .in_clk    (in_clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .dir_toggle(dir_toggle),
        .load      (load),
        .load_val  (load_val),
        .q         (q),
        .tens      (tens),
        .ones      (ones),
        .up        (up),
        .running   (running),
        .tick      (tick)
    );

    always #5 in_clk = ~in_clk;

    typedef struct {
        bit s, p, t, l;
        int v;
        int eq;
        bit eup, erun, etick;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int eq, input bit eup, input bit erun,
                            input bit etick);
        chk({tag, "_q"}, 32'(q), eq);
        chk({tag, "_tens"}, 32'(tens), eq / 10);
        chk({tag, "_ones"}, 32'(ones), eq % 10);
        chk({tag, "_up"}, 32'(up), 32'(eup));
        chk({tag, "_running"}, 32'(running), 32'(erun));
        chk({tag, "_tick"}, 32'(tick), 32'(etick));
    endtask

    // One clock: pulses driven at negedge, held across one rising edge, sampled 1 time unit later.
    task automatic cyc(input bit s, input bit p, input bit t, input bit l, input int v);
        @(negedge in_clk);
        start = s; stop = p; dir_toggle = t; load = l; load_val = 7'(v);
        @(posedge in_clk);
        #1;
        start = 0; stop = 0; dir_toggle = 0; load = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge in_clk);
        rst = 1'b1;
        @(negedge in_clk);
        rst = 1'b0;
        m_st = 0; m_q = 0; m_cnt = 0; m_up = 1'b1;
    endtask

    function automatic bit m_at_lim();
        return (m_up && m_q == 99) || (!m_up && m_q == 0);
    endfunction

    function automatic bit m_tick();
        return (m_st == 1) && (m_cnt % TD == TD - 1);
    endfunction

    task automatic model_step(input bit s, input bit p, input bit t, input bit l, input int v);
        int nst, nq, ncnt, lv;
        bit tk;
        tk   = m_tick();
        nst  = m_st;
        nq   = m_q;
        ncnt = (m_st == 1) ? m_cnt + 1 : 0;
        lv   = (v > 99) ? 99 : v;
        if (tk) begin
`ifdef COUNT_SEQ_LIMIT_STOP_EN
            if (m_at_lim()) nst = 3;
            else nq = m_up ? (m_q + 1) % 100 : (m_q + 99) % 100;
`else
            nq = m_up ? (m_q + 1) % 100 : (m_q + 99) % 100;
`endif
        end
        case (m_st)
            0: if (s) begin nst = 1; ncnt = 0; end else if (l && !p) nq = lv;
            1: if (p) nst = 2;
            2: if (p) begin nst = 0; nq = 0; end
               else if (s) begin nst = 1; ncnt = 0; end
               else if (l) nq = lv;
            3: if (p) begin nst = 0; nq = 0; end
               else if (s && !m_at_lim()) begin nst = 1; ncnt = 0; end
            default: nst = 0;
        endcase
        m_st  = nst;
        m_q   = nq;
        m_cnt = ncnt;
        m_up  = m_up ^ t;
    endtask

    initial begin
        tbl[0]  = '{1, 0, 0, 0, 0,   0,  1, 1, 0};
        tbl[1]  = '{0, 0, 0, 0, 0,   0,  1, 1, 0};
        tbl[2]  = '{0, 0, 0, 0, 0,   0,  1, 1, 0};
        tbl[3]  = '{0, 0, 0, 0, 0,   0,  1, 1, 1};
        tbl[4]  = '{0, 0, 0, 0, 0,   1,  1, 1, 0};
        tbl[5]  = '{0, 0, 0, 0, 0,   1,  1, 1, 0};
        tbl[6]  = '{0, 0, 0, 0, 0,   1,  1, 1, 0};
        tbl[7]  = '{0, 0, 0, 0, 0,   1,  1, 1, 1};
        tbl[8]  = '{0, 0, 0, 0, 0,   2,  1, 1, 0};
        tbl[9]  = '{1, 1, 0, 0, 0,   2,  1, 0, 0};
        tbl[10] = '{0, 0, 0, 0, 0,   2,  1, 0, 0};
        tbl[11] = '{0, 0, 0, 1, 120, 99, 1, 0, 0};
        tbl[12] = '{0, 1, 0, 0, 0,   0,  1, 0, 0};
        tbl[13] = '{0, 0, 0, 1, 45,  45, 1, 0, 0};
        tbl[14] = '{0, 1, 0, 1, 77,  45, 1, 0, 0};
        tbl[15] = '{0, 0, 1, 0, 0,   45, 0, 0, 0};
        tbl[16] = '{0, 0, 1, 0, 0,   45, 1, 0, 0};

        #12;
        chk_outs("reset", 0, 1, 0, 0);
        do_reset();

        foreach (tbl[i]) begin
            cyc(tbl[i].s, tbl[i].p, tbl[i].t, tbl[i].l, tbl[i].v);
            chk_outs($sformatf("vec%0d", i), tbl[i].eq, tbl[i].eup, tbl[i].erun, tbl[i].etick);
        end

        // Saturated load, then run into the upper boundary.
        do_reset();
        cyc(0, 0, 0, 1, 120);
        chk_outs("sat_load", 99, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        idle(4);
`ifdef COUNT_SEQ_LIMIT_STOP_EN
        chk_outs("up_limit", 99, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk_outs("done_start_ignored", 99, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk_outs("done_restart", 99, 0, 1, 0);
        idle(4);
        chk_outs("done_restart_step", 98, 0, 1, 0);
`else
        chk_outs("up_wrap", 0, 1, 1, 0);
`endif

        // Count down from zero, then stop twice.
        do_reset();
        cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        idle(4);
`ifdef COUNT_SEQ_LIMIT_STOP_EN
        chk_outs("down_limit", 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk_outs("done_stop", 0, 0, 0, 0);
`else
        chk_outs("down_wrap", 99, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        chk_outs("stop_pause", 99, 0, 0, 0);
`endif
        cyc(0, 1, 0, 0, 0);
        chk_outs("stop_clear", 0, 0, 0, 0);

        // Asynchronous reset in the middle of a run.
        do_reset();
        cyc(0, 0, 0, 1, 37);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk_outs("pre_rst", 37, 0, 1, 0);
        @(negedge in_clk);
        start = 1'b1;
        rst = 1'b1;
        #1;
        chk_outs("async_rst", 0, 1, 0, 0);
        @(posedge in_clk);
        #1;
        chk_outs("rst_held", 0, 1, 0, 0);
        @(negedge in_clk);
        rst = 1'b0;
        start = 1'b0;
        @(posedge in_clk);
        #1;
        chk_outs("rst_release", 0, 1, 0, 0);

        // Direction toggle coinciding with a tick uses the old direction for that step.
        do_reset();
        cyc(0, 0, 0, 1, 50);
        cyc(1, 0, 0, 0, 0);
        idle(3);
        chk_outs("tick_at_50", 50, 1, 1, 1);
        cyc(0, 0, 1, 0, 0);
        chk_outs("toggle_on_tick", 51, 0, 1, 0);
        idle(4);
        chk_outs("after_toggle", 50, 0, 1, 0);

        // Random pulses against the reference model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bit s, p, t, l;
            int v;
            s = ($urandom_range(0, 7) == 0);
            p = ($urandom_range(0, 11) == 0);
            t = ($urandom_range(0, 15) == 0);
            l = ($urandom_range(0, 7) == 0);
            v = $urandom_range(0, 127);
            model_step(s, p, t, l, v);
            cyc(s, p, t, l, v);
            chk_outs($sformatf("rand%0d", n), m_q, m_up, m_st == 1, m_tick());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
